// File: rtl/arb_pkg.sv
// Shared constants and helpers for the 4-requester round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ       = 4;
  localparam int unsigned PTR_W       = 2;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned DEF_TIMEOUT = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Index of the set bit in a one-hot vector (0 when all-zero).
  function automatic logic [PTR_W-1:0] onehot_idx(input logic [N_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Circular priority search: first set Req bit starting at index Ptr+1.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] Req,
  input  logic [PTR_W-1:0] Ptr,
  output logic [N_REQ-1:0] pick
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = PTR_W'(Ptr + PTR_W'(k));
      if (!found && Req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Two-state round-robin arbiter for 4 requesters with registered grant.
// Optional grant-hold timeout enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] Req,
  input  logic             Done,
  output logic [N_REQ-1:0] Gnt,
  output logic             Vld,
  output logic             Tmo
);

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             vld_q, vld_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] pick;
  logic             release_c;

  rr_pick4 u_pick (
    .Req  (Req),
    .Ptr  (ptr_q),
    .pick (pick)
  );

  // Owner lets go, either explicitly or by dropping its request.
  assign release_c = Done || ((Req & gnt_q) == '0);

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (Req != '0) begin
          state_d = ST_GRANT;
          gnt_d   = pick;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        // Normal release wins over a coincident timeout.
        if (release_c || (cnt_q == CNT_W'(TIMEOUT))) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = onehot_idx(gnt_q);
          cnt_d   = '0;
          tmo_d   = !release_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
    vld_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign Tmo = tmo_q;
`else
  logic unused_timeout;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (Req != '0) begin
          state_d = ST_GRANT;
          gnt_d   = pick;
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = onehot_idx(gnt_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    vld_d = |gnt_d;
  end

  assign unused_timeout = ^CNT_W'(TIMEOUT);
  assign Tmo            = 1'b0;
`endif

  // Reset leaves Ptr at 3 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      ptr_q   <= PTR_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Gnt = gnt_q;
  assign Vld = vld_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4; timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] Req;
  logic       Done;
  logic [3:0] Gnt;
  logic       Vld;
  logic       Tmo;

  int tests_run;
  int tests_failed;

  rr_arbiter4 #(.TIMEOUT(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .Req  (Req),
    .Done (Done),
    .Gnt  (Gnt),
    .Vld  (Vld),
    .Tmo  (Tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, settle, and check the grant/valid invariants.
  task automatic step();
    logic [3:0] g;
    @(posedge clk);
    #1;
    g = Gnt;
    tests_run++;
    if ((g & (g - 4'd1)) !== 4'b0000 || Vld !== (|g)) begin
      tests_failed++;
      $display("FAIL invariant: Gnt=%b Vld=%b required one-hot-or-zero with Vld=|Gnt", g, Vld);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    Req  = 4'b0000;
    Done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (Gnt !== 4'b0000 || Vld !== 1'b0 || Tmo !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: Gnt=%b Vld=%b Tmo=%b required 0000/0/0", Gnt, Vld, Tmo);
    end
  endtask

  task automatic test_basic();
    do_reset();
    Req = 4'b0101;
    step();
    tests_run++;
    if (Gnt !== 4'b0001 || Vld !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_first: Gnt=%b Vld=%b required 0001/1", Gnt, Vld);
    end
    Done = 1'b1;
    step();
    Done = 1'b0;
    tests_run++;
    if (Gnt !== 4'b0000 || Vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_gap: Gnt=%b Vld=%b required 0000/0", Gnt, Vld);
    end
    step();
    tests_run++;
    if (Gnt !== 4'b0100) begin
      tests_failed++;
      $display("FAIL basic_second: Gnt=%b required 0100", Gnt);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_seq [9];
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    Req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      step();
      tests_run++;
      if (Gnt !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL rotation[%0d]: Gnt=%b required %b", i, Gnt, exp_seq[i]);
      end
      Done = (exp_seq[i] != 4'b0000);
    end
    Done = 1'b0;
  endtask

  task automatic test_owner_drop();
    do_reset();
    Req = 4'b0010;
    step();
    tests_run++;
    if (Gnt !== 4'b0010) begin
      tests_failed++;
      $display("FAIL drop_owner: Gnt=%b required 0010", Gnt);
    end
    Req = 4'b1101;
    step();
    tests_run++;
    if (Gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL drop_release: Gnt=%b required 0000", Gnt);
    end
    step();
    tests_run++;
    if (Gnt !== 4'b0100) begin
      tests_failed++;
      $display("FAIL drop_next: Gnt=%b required 0100", Gnt);
    end
    // Non-owner request churn during a grant must not disturb it.
    Req = 4'b1111;
    step();
    Req = 4'b0100;
    step();
    tests_run++;
    if (Gnt !== 4'b0100) begin
      tests_failed++;
      $display("FAIL drop_hold: Gnt=%b required 0100", Gnt);
    end
    Done = 1'b1;
    step();
    Done = 1'b0;
    Req  = 4'b0000;
  endtask

  task automatic test_done_idle();
    do_reset();
    Done = 1'b1;
    step();
    step();
    tests_run++;
    if (Gnt !== 4'b0000 || Vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_idle_quiet: Gnt=%b Vld=%b required 0000/0", Gnt, Vld);
    end
    Req = 4'b0010;
    step();
    Done = 1'b0;
    tests_run++;
    if (Gnt !== 4'b0010) begin
      tests_failed++;
      $display("FAIL done_idle_grant: Gnt=%b required 0010", Gnt);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    Req = 4'b1000;
    step();
    tests_run++;
    if (Gnt !== 4'b1000) begin
      tests_failed++;
      $display("FAIL rst_mid_owner: Gnt=%b required 1000", Gnt);
    end
    rst = 1'b1;
    step();
    tests_run++;
    if (Gnt !== 4'b0000 || Vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_clear: Gnt=%b Vld=%b required 0000/0", Gnt, Vld);
    end
    rst = 1'b0;
    Req = 4'b1001;
    step();
    tests_run++;
    if (Gnt !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rst_mid_ptr: Gnt=%b required 0001", Gnt);
    end
    Req = 4'b0000;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    Req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (Gnt !== 4'b0001 || Tmo !== 1'b0) begin
        tests_failed++;
        $display("FAIL tmo_hold[%0d]: Gnt=%b Tmo=%b required 0001/0", i, Gnt, Tmo);
      end
    end
    step();
    tests_run++;
    if (Gnt !== 4'b0000 || Tmo !== 1'b1) begin
      tests_failed++;
      $display("FAIL tmo_fire: Gnt=%b Tmo=%b required 0000/1", Gnt, Tmo);
    end
    step();
    tests_run++;
    if (Gnt !== 4'b0001 || Tmo !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_regrant: Gnt=%b Tmo=%b required 0001/0", Gnt, Tmo);
    end
    // Done on the cycle the counter hits the limit is a normal release.
    step();
    step();
    step();
    Done = 1'b1;
    step();
    Done = 1'b0;
    tests_run++;
    if (Gnt !== 4'b0000 || Tmo !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_coincide: Gnt=%b Tmo=%b required 0000/0", Gnt, Tmo);
    end
    Req = 4'b0000;
  endtask
`else
  task automatic test_timeout();
    do_reset();
    Req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step();
      tests_run++;
      if (Gnt !== 4'b0001 || Tmo !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_forever[%0d]: Gnt=%b Tmo=%b required 0001/0", i, Gnt, Tmo);
      end
    end
    Req = 4'b0000;
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst  = 1'b1;
    Req  = 4'b0000;
    Done = 1'b0;
    test_reset();
    test_basic();
    test_rotation();
    test_owner_drop();
    test_done_idle();
    test_reset_mid_grant();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
